regfile_wr_arbiter: RTL

Shares the single register-file write port between the in-order pipeline write-back path and the multi-cycle multiply/divide unit (MDU), which returns results asynchronously to the pipeline. The pipeline always wins the port. MDU results are buffered in a small FIFO and drained into idle write slots. A starvation counter forces a pipeline bubble when the buffer cannot drain. It sits between the WB stage outputs and the register file, and exports a pending-write mask to decode so that RAW/WAW hazards against buffered results stall in ID.

---
 rtl/regfile_wr_arbiter_pkg.sv | 23 ++
 rtl/regfile_wr_arbiter_wr_fifo.sv | 87 ++++++++
 rtl/regfile_wr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_pkg
// Description : Shared widths and starve-FSM encodings for the RF write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } starve_state_e;

    function automatic logic [31:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        return 32'd1 << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wr_fifo
// Description : DEPTH-entry FIFO of pending MDU register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int   DEPTH = 2,
    localparam int  CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [REG_ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [CNT_W-1:0]            count,
    output logic [REG_ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]           head_data,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Guards keep pointers sane even if a caller misbehaves.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr]  <= push_addr;
                r_data[r_wr_ptr]  <= push_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_addr   = r_addr[r_rd_ptr];
    assign head_data   = r_data[r_rd_ptr];
    assign entry_valid = r_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_addr[gi*REG_ADDR_W +: REG_ADDR_W] = r_addr[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the RF write port between WB and buffered MDU results.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_regWr,
    input  logic [REG_ADDR_W-1:0] wb_regAddr,
    input  logic [DATA_W-1:0]     wb_regData,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0]     wData,
    output logic                  stall_req,
    output logic [31:0]           busy_mask
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        w_full;
    logic                        w_empty;
    logic [CNT_W-1:0]            w_count;
    logic [REG_ADDR_W-1:0]       w_head_addr;
    logic [DATA_W-1:0]           w_head_data;
    logic [DEPTH-1:0]            w_entry_valid;
    logic [DEPTH*REG_ADDR_W-1:0] w_entry_addr;
    logic                        w_pipe_live;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_drains;
    logic [31:0]                 w_mask;

    starve_state_e r_state;
    logic [3:0]    r_starve_cnt;

    assign w_pipe_live = wb_regWr && (wb_regAddr != '0);
    assign mdu_ready   = !w_full && !rst;
    // r0 results are accepted from the MDU but never stored.
    assign w_push      = mdu_valid && mdu_ready && (mdu_addr != '0);
    assign w_pop       = !w_pipe_live && !w_empty && !rst;
    assign w_drains    = (w_count == CNT_W'(1)) && !w_push;

    wr_fifo #(
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_addr   (mdu_addr),
        .push_data   (mdu_data),
        .pop         (w_pop),
        .full        (w_full),
        .empty       (w_empty),
        .count       (w_count),
        .head_addr   (w_head_addr),
        .head_data   (w_head_data),
        .entry_valid (w_entry_valid),
        .entry_addr  (w_entry_addr)
    );

    always_comb begin
        we    = 1'b0;
        wAddr = '0;
        wData = '0;
        if (!rst) begin
            if (w_pipe_live) begin
                we    = 1'b1;
                wAddr = wb_regAddr;
                wData = wb_regData;
            end else if (!w_empty) begin
                we    = 1'b1;
                wAddr = w_head_addr;
                wData = w_head_data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_mask = w_mask | addr_onehot(w_entry_addr[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
        busy_mask = w_mask & ~32'd1;
    end

    // WAIT is only ever occupied with a non-empty FIFO, so a live pipeline slot
    // there is by definition a blocked drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            stall_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_starve_cnt <= '0;
                    if (w_push) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_pop) begin
                        r_starve_cnt <= '0;
                        if (w_drains) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_pipe_live) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                        if (r_starve_cnt == 4'(STARVE_MAX - 1)) begin
                            r_state   <= ST_FORCE;
                            stall_req <= 1'b1;
                        end
                    end
                end
                ST_FORCE: begin
                    if (w_pop) begin
                        r_starve_cnt <= '0;
                        stall_req    <= 1'b0;
                        r_state      <= w_drains ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_starve_cnt <= '0;
                    stall_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
